// File: rtl/arb_pkg.sv
// Shared definitions for the sample-memory address arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Requester slots as wired in the FIR datapath.
    localparam int CH_FIR = 0;
    localparam int CH_AXI = 1;

    // Width of a channel index; at least one bit even for tiny configurations.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select. Fixed priority scans from channel 0;
// round-robin scans from rr_ptr+1 and wraps, so the last owner is checked last.
module arb_pick
    import arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter bit RR_MODE = 1'b1,
    localparam int CW     = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     rr_ptr,
    output logic [CW-1:0]     winner,
    output logic              found
);

    logic [CW:0] start_v;
    logic [CW:0] idx_v;

    // Scan NUM_CH slots from the start point and keep the first active request.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        start_v = RR_MODE ? ({1'b0, rr_ptr} + (CW+1)'(1)) : '0;
        if (start_v >= (CW+1)'(NUM_CH)) start_v = start_v - (CW+1)'(NUM_CH);
        idx_v   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_v = start_v + (CW+1)'(i);
            if (idx_v >= (CW+1)'(NUM_CH)) idx_v = idx_v - (CW+1)'(NUM_CH);
            if (!found && req[idx_v[CW-1:0]]) begin
                found  = 1'b1;
                winner = idx_v[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/addr_arbiter.sv
// Registered N-channel arbiter for the sample RAM address port.
// Owner keeps the port while it requests, yielding after MAX_BURST beats only
// if someone else is waiting. force_en hands the port to force_ch directly.
// Interface contract: req[i] high = one beat wanted this cycle; out_valid high
// = out_addr is a beat to memory; there is no backpressure, every valid cycle
// is consumed.
module addr_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH     = 13,
    parameter int NUM_CH    = 2,
    parameter bit RR_MODE   = 1'b1,
    parameter int MAX_BURST = 4,
    localparam int CW       = ch_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*WIDTH-1:0] addr,
    input  logic                    force_en,
    input  logic [CW-1:0]           force_ch,
    output logic [NUM_CH-1:0]       gnt,
    output logic [CW-1:0]           cur_ch,
    output logic [WIDTH-1:0]        out_addr,
    output logic                    out_valid
);

    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);

    arb_state_t        state;
    logic [BW-1:0]     burst_cnt;
    logic [CW-1:0]     rr_ptr;

    logic [WIDTH-1:0]  addr_ch [NUM_CH];
    logic [NUM_CH-1:0] owner_mask;
    logic              owner_req;
    logic              others_req;
    logic              below_limit;
    logic              keep_owner;
    logic              force_hit;
    logic [CW-1:0]     pick_ch;
    logic              pick_found;
    logic              owner_change;

    // An out-of-range forced index behaves as if force were off.
    if ((1 << CW) == NUM_CH) begin : g_force_full
        assign force_hit = force_en;
    end else begin : g_force_part
        assign force_hit = force_en && (force_ch < CW'(NUM_CH));
    end

    // Unflatten the per-channel address bus.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) addr_ch[i] = addr[i*WIDTH +: WIDTH];
    end

    // Decide whether the current owner holds on or arbitration reruns.
    always_comb begin
        owner_mask   = NUM_CH'(1) << cur_ch;
        owner_req    = req[cur_ch];
        others_req   = |(req & ~owner_mask);
        below_limit  = burst_cnt < BW'(MAX_BURST - 1);
        keep_owner   = (state == ARB_BUSY) && owner_req && (!others_req || below_limit);
        owner_change = (state == ARB_IDLE) || (pick_ch != cur_ch);
    end

    arb_pick #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick_ch),
        .found  (pick_found)
    );

    // Ownership FSM with registered grant, address and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
            rr_ptr    <= CW'(NUM_CH - 1);
            gnt       <= '0;
            cur_ch    <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
        end else if (force_hit) begin
            state     <= req[force_ch] ? ARB_BUSY : ARB_IDLE;
            burst_cnt <= '0;
            cur_ch    <= force_ch;
            gnt       <= NUM_CH'(1) << force_ch;
            out_valid <= req[force_ch];
            if (req[force_ch]) out_addr <= addr_ch[force_ch];
        end else if (!pick_found) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            out_valid <= 1'b0;
        end else if (keep_owner) begin
            gnt       <= owner_mask;
            out_valid <= 1'b1;
            out_addr  <= addr_ch[cur_ch];
            if (below_limit) burst_cnt <= burst_cnt + BW'(1);
        end else begin
            state     <= ARB_BUSY;
            cur_ch    <= pick_ch;
            gnt       <= NUM_CH'(1) << pick_ch;
            out_valid <= 1'b1;
            out_addr  <= addr_ch[pick_ch];
            if (owner_change) begin
                burst_cnt <= '0;
                rr_ptr    <= pick_ch;
            end else if (below_limit) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_addr_arbiter.sv
// Bench for addr_arbiter: three configurations driven from one shared stimulus
// (4ch round-robin, 2ch fixed priority, 3ch round-robin with MAX_BURST=2),
// each checked against an arbitration reference model.
module tb_addr_arbiter;

    localparam int W = 13;

    // ---------------- clock / reset / shared stimulus
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req = '0;
    logic [W-1:0] a [4];
    logic force_en = 1'b0;
    logic [1:0] force_ch = '0;
    logic [4*W-1:0] addr_bus;

    always #5 clk = ~clk;
    assign addr_bus = {a[3], a[2], a[1], a[0]};

    // ---------------- DUTs
    logic [3:0] g4;  logic [1:0] c4; logic [W-1:0] oa4; logic v4;
    logic [1:0] g2;  logic       c2; logic [W-1:0] oa2; logic v2;
    logic [2:0] g3;  logic [1:0] c3; logic [W-1:0] oa3; logic v3;

    addr_arbiter #(.WIDTH(W), .NUM_CH(4), .RR_MODE(1'b1), .MAX_BURST(4)) u4 (
        .clk(clk), .rst(rst), .req(req), .addr(addr_bus), .force_en(force_en),
        .force_ch(force_ch), .gnt(g4), .cur_ch(c4), .out_addr(oa4), .out_valid(v4));

    addr_arbiter #(.WIDTH(W), .NUM_CH(2), .RR_MODE(1'b0), .MAX_BURST(4)) u2f (
        .clk(clk), .rst(rst), .req(req[1:0]), .addr(addr_bus[2*W-1:0]), .force_en(force_en),
        .force_ch(force_ch[0]), .gnt(g2), .cur_ch(c2), .out_addr(oa2), .out_valid(v2));

    addr_arbiter #(.WIDTH(W), .NUM_CH(3), .RR_MODE(1'b1), .MAX_BURST(2)) u3 (
        .clk(clk), .rst(rst), .req(req[2:0]), .addr(addr_bus[3*W-1:0]), .force_en(force_en),
        .force_ch(force_ch), .gnt(g3), .cur_ch(c3), .out_addr(oa3), .out_valid(v3));

    logic [3:0]   act_gnt   [3];
    logic         act_valid [3];
    logic [W-1:0] act_addr  [3];
    logic [1:0]   act_ch    [3];

    assign act_gnt[0] = g4;            assign act_ch[0] = c4;
    assign act_gnt[1] = {2'b00, g2};   assign act_ch[1] = {1'b0, c2};
    assign act_gnt[2] = {1'b0, g3};    assign act_ch[2] = c3;
    assign act_valid[0] = v4;  assign act_addr[0] = oa4;
    assign act_valid[1] = v2;  assign act_addr[1] = oa2;
    assign act_valid[2] = v3;  assign act_addr[2] = oa3;

    // ---------------- reference model
    int nch [3] = '{4, 2, 3};
    int rrm [3] = '{1, 0, 1};
    int mb  [3] = '{4, 4, 2};

    bit           m_busy  [3];
    int           m_owner [3];
    int           m_cnt   [3];
    int           m_ptr   [3];
    logic [3:0]   e_gnt   [3];
    logic         e_valid [3];
    logic [W-1:0] e_addr  [3];
    logic [1:0]   e_ch    [3];

    int vectors = 0;
    int miscompares = 0;

    // One clock edge of the arbitration rules for configuration k.
    task automatic model_step(input int k);
        int n, fc, w, c;
        logic [3:0] r;
        bit others, newo;
        n  = nch[k];
        fc = (k == 1) ? int'(force_ch[0]) : int'(force_ch);
        r  = req & 4'((1 << n) - 1);
        if (rst) begin
            m_busy[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_ptr[k] = n - 1;
            e_gnt[k] = '0; e_valid[k] = 1'b0; e_addr[k] = '0;
        end else if (force_en && fc < n) begin
            m_owner[k] = fc; m_cnt[k] = 0; m_busy[k] = r[fc];
            e_gnt[k] = 4'(1 << fc); e_valid[k] = r[fc];
            if (r[fc]) e_addr[k] = a[fc];
        end else if (r == 4'b0) begin
            m_busy[k] = 0; e_gnt[k] = '0; e_valid[k] = 1'b0;
        end else begin
            others = (r & ~(4'b1 << m_owner[k])) != 4'b0;
            if (m_busy[k] && r[m_owner[k]] && (!others || m_cnt[k] < mb[k] - 1)) begin
                w = m_owner[k];
            end else begin
                w = -1;
                for (int i = 0; i < n; i++) begin
                    c = rrm[k] ? (m_ptr[k] + 1 + i) % n : i;
                    if (w < 0 && r[c]) w = c;
                end
            end
            newo = !m_busy[k] || (w != m_owner[k]);
            if (newo) begin
                m_cnt[k] = 0; m_ptr[k] = w;
            end else if (m_cnt[k] < mb[k] - 1) begin
                m_cnt[k]++;
            end
            m_owner[k] = w; m_busy[k] = 1;
            e_gnt[k] = 4'(1 << w); e_valid[k] = 1'b1; e_addr[k] = a[w];
        end
        e_ch[k] = 2'(m_owner[k]);
    endtask

    // Advance one clock: model follows the edge, outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; force_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst = 1'b1; req = '0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({act_gnt[k], act_valid[k], act_addr[k], act_ch[k]} !== {4'b0, 1'b0, 13'd0, 2'd0}) begin
                miscompares++;
                $display("FAIL reset dut%0d got gnt=%b valid=%b addr=%0d ch=%0d want all zero",
                         k, act_gnt[k], act_valid[k], act_addr[k], act_ch[k]);
            end
        end
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if ({act_gnt[k], act_valid[k], act_addr[k]} !== {e_gnt[k], e_valid[k], e_addr[k]}) begin
                    miscompares++;
                    $display("FAIL idle dut%0d got gnt=%b valid=%b addr=%0d want gnt=%b valid=%b addr=%0d",
                             k, act_gnt[k], act_valid[k], act_addr[k], e_gnt[k], e_valid[k], e_addr[k]);
                end
            end
        end
    endtask

    task automatic test_single();
        a[0] = 13'd10; req = 4'b0001;
        tick();
        vectors++;
        if ({g2, oa2, v2} !== {2'b01, 13'd10, 1'b1}) begin
            miscompares++;
            $display("FAIL single_grant got gnt=%b addr=%0d valid=%b want gnt=01 addr=10 valid=1", g2, oa2, v2);
        end
        req = 4'b0000;
        tick();
        vectors++;
        if ({g2, v2} !== {2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL single_drop got gnt=%b valid=%b want gnt=00 valid=0", g2, v2);
        end
    endtask

    task automatic test_fixed_priority();
        a[0] = 13'd100; a[1] = 13'd55; req = 4'b0011;
        for (int t = 0; t < 10; t++) begin
            tick();
            vectors++;
            if ({g2, oa2, v2} !== {2'b01, 13'd100, 1'b1}) begin
                miscompares++;
                $display("FAIL fixed_prio beat %0d got gnt=%b addr=%0d valid=%b want gnt=01 addr=100 valid=1",
                         t, g2, oa2, v2);
            end
        end
    endtask

    task automatic test_rr_burst();
        logic [3:0]   want_g;
        logic [W-1:0] want_a;
        apply_reset();
        a[0] = 13'd100; a[1] = 13'd55; req = 4'b0011;
        for (int t = 0; t < 12; t++) begin
            tick();
            want_g = (t >= 4 && t < 8) ? 4'b0010 : 4'b0001;
            want_a = (t >= 4 && t < 8) ? 13'd55 : 13'd100;
            vectors++;
            if ({g4, oa4, v4} !== {want_g, want_a, 1'b1}) begin
                miscompares++;
                $display("FAIL rr_burst beat %0d got gnt=%b addr=%0d valid=%b want gnt=%b addr=%0d valid=1",
                         t, g4, oa4, v4, want_g, want_a);
            end
            vectors++;
            if ({g3, oa3, v3} !== {e_gnt[2][2:0], e_addr[2], e_valid[2]}) begin
                miscompares++;
                $display("FAIL rr_burst3 beat %0d got gnt=%b addr=%0d valid=%b want gnt=%b addr=%0d valid=%b",
                         t, g3, oa3, v3, e_gnt[2][2:0], e_addr[2], e_valid[2]);
            end
        end
    endtask

    task automatic test_force();
        force_en = 1'b1; force_ch = 2'd1; req = 4'b0001;
        tick();
        vectors++;
        if ({g4, v4} !== {4'b0010, 1'b0}) begin
            miscompares++;
            $display("FAIL force_noreq got gnt=%b valid=%b want gnt=0010 valid=0", g4, v4);
        end
        req = 4'b0011;
        tick();
        vectors++;
        if ({g4, oa4, v4} !== {4'b0010, 13'd55, 1'b1}) begin
            miscompares++;
            $display("FAIL force_req got gnt=%b addr=%0d valid=%b want gnt=0010 addr=55 valid=1", g4, oa4, v4);
        end
        force_en = 1'b0;
        tick();
        vectors++;
        if ({g4, oa4, v4} !== {4'b0010, 13'd55, 1'b1}) begin
            miscompares++;
            $display("FAIL force_release got gnt=%b addr=%0d valid=%b want gnt=0010 addr=55 valid=1", g4, oa4, v4);
        end
        // Index 3 is out of range for the 3-channel instance and must be ignored there.
        force_en = 1'b1; force_ch = 2'd3; req = 4'b0001;
        tick();
        vectors++;
        if ({g3, v3, g4, v4} !== {3'b001, 1'b1, 4'b1000, 1'b0}) begin
            miscompares++;
            $display("FAIL force_range got gnt3=%b valid3=%b gnt4=%b valid4=%b want gnt3=001 valid3=1 gnt4=1000 valid4=0",
                     g3, v3, g4, v4);
        end
        force_en = 1'b0; req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        a[2] = 13'd77; req = 4'b0100;
        tick(); tick();
        vectors++;
        if ({g4, oa4, v4} !== {4'b0100, 13'd77, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_burst got gnt=%b addr=%0d valid=%b want gnt=0100 addr=77 valid=1", g4, oa4, v4);
        end
        rst = 1'b1; req = 4'b1111;
        tick();
        vectors++;
        if ({g4, c4, oa4, v4} !== {4'b0000, 2'd0, 13'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset got gnt=%b ch=%0d addr=%0d valid=%b want all zero", g4, c4, oa4, v4);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({g4, c4} !== {4'b0001, 2'd0}) begin
            miscompares++;
            $display("FAIL post_reset got gnt=%b ch=%0d want gnt=0001 ch=0", g4, c4);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) a[i] = W'($urandom_range(0, 8191));
            force_en = ($urandom_range(0, 7) == 0);
            force_ch = 2'($urandom_range(0, 3));
            rst      = ($urandom_range(0, 63) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if ({act_gnt[k], act_valid[k], act_addr[k], act_ch[k]} !==
                    {e_gnt[k], e_valid[k], e_addr[k], e_ch[k]}) begin
                    miscompares++;
                    $display("FAIL random t=%0d dut%0d got gnt=%b valid=%b addr=%0d ch=%0d want gnt=%b valid=%b addr=%0d ch=%0d",
                             t, k, act_gnt[k], act_valid[k], act_addr[k], act_ch[k],
                             e_gnt[k], e_valid[k], e_addr[k], e_ch[k]);
                end
            end
        end
        rst = 1'b0; force_en = 1'b0;
    endtask

    // ---------------- sequence and report
    initial begin
        for (int i = 0; i < 4; i++) a[i] = '0;
        test_reset();
        test_single();
        test_fixed_priority();
        test_rr_burst();
        test_force();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addr_arbiter.md
# addr_arbiter

Registered N-channel address arbiter. It generalises the 2:1 FIR/AXI sample-address select into a block that arbitrates between NUM_CH requesters (channel 0 = FIR engine, channel 1 = AXI slave, higher channels spare) for the sample-memory address port. It provides fixed-priority or round-robin arbitration, a per-owner burst limit, and an FSM force override. It sits between the requesters and the sample RAM address/enable pins.

## Interface
- WIDTH, 13, address width in bits.
- NUM_CH, 2, number of requesters; legal range 2..8.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- MAX_BURST, 4, maximum consecutive beats one owner keeps while another channel waits; legal range 1..16.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel request; one beat per cycle held high.
- addr  in  NUM_CH*WIDTH  flattened addresses; channel i at [i*WIDTH +: WIDTH].
- force_en  in  1  FSM override; bypasses arbitration.
- force_ch  in  $clog2(NUM_CH)  channel forced when force_en=1.
- gnt  out  NUM_CH  one-hot grant, registered; all zero when idle.
- cur_ch  out  $clog2(NUM_CH)  index of current/last owner.
- out_addr  out  WIDTH  registered address to memory.
- out_valid  out  1  memory enable; out_addr is meaningful only when out_valid=1.

## Operation
- States: IDLE (no owner) and BUSY (owner held in cur_ch).
- IDLE -> BUSY when any req is high; the winner is picked by mode.
- BUSY -> BUSY with the same owner while req[owner]=1 and either no other req is high or burst_cnt < MAX_BURST-1.
- BUSY -> BUSY with a new owner when req[owner] drops while others request, or when the burst limit is hit while others request.
- BUSY -> IDLE when req is all zero.
- Fixed priority: the lowest-index active req wins.
- Round-robin: search starts at rr_ptr+1 and wraps modulo NUM_CH. rr_ptr updates to the new owner on every ownership change.
- burst_cnt: resets to 0 on an ownership change and increments per beat. It saturates at MAX_BURST-1 when no competitor exists, so the owner keeps the grant indefinitely.
- Force: while force_en=1, owner = force_ch and out_valid = req[force_ch]. burst_cnt is held at 0 and rr_ptr is unchanged. When force_en deasserts, normal arbitration resumes in the same cycle.
- A force_ch value >= NUM_CH is treated as force_en=0.
- Beat accounting: a beat is one cycle in which out_valid=1; no backpressure exists.
- Reset values: gnt=0, out_valid=0, out_addr=0, cur_ch=0, burst_cnt=0, state=IDLE, rr_ptr=NUM_CH-1 (so channel 0 wins first in RR).
- rst asserted mid-burst takes effect at the next edge, and all outputs return to reset values in that cycle.

## Timing
- Latency: one cycle. req/addr sampled at edge t; gnt, cur_ch, out_addr and out_valid reflect that decision after edge t and are stable through cycle t+1.
- out_addr is the addr of the winning channel captured at edge t, not a live mux.
- Handover costs no idle cycle: the last beat of the old owner at t is followed by the first beat of the new owner at t+1.
- Simultaneous requests: resolved by mode. With one requester there is no arbitration delay.
- When req[owner] drops, gnt to that channel clears at the next edge, never later.
- gnt is always one-hot or zero; out_valid=1 implies gnt != 0.

## Structure
- Shared package arb_pkg: state enum (ARB_IDLE, ARB_BUSY), channel-index width function, FIR/AXI channel index constants (CH_FIR=0, CH_AXI=1).
- One sub-module, arb_pick: a combinational winner select taking req, rr_ptr and RR_MODE and returning the winner index and a found flag. It is reused for both modes.

## Test plan
- Reset then idle: with rst=1 for 2 cycles and req=0, after release gnt=0, out_valid=0, out_addr=0 for 5 cycles.
- Single channel, NUM_CH=2: req=01, addr0=10. The next cycle has gnt=01, out_addr=10, out_valid=1. When req drops, gnt=00 one cycle later.
- Fixed priority, RR_MODE=0: req=11 held for 10 cycles with addr0=100, addr1=55. Channel 0 is granted on every beat, because the burst limit yields only to an equal-or-lower winner.
- Round-robin burst: RR_MODE=1, MAX_BURST=4, req=11 continuous. Expected gnt sequence is 01×4, 10×4, 01×4, with out_addr alternating 100/55 per block and no gap cycles.
- Force override: force_en=1, force_ch=1, req=01. Expect gnt=10, out_valid=0. Then req=11 gives out_addr=55, out_valid=1. Deasserting force_en returns to RR with no lost beat.
- Reset mid-burst, NUM_CH=4: grant to ch2 in its 2nd beat, assert rst for 1 cycle. All outputs reach reset values the next cycle, and the first post-reset grant with req=1111 goes to ch0.
